// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: writes one byte to an HD44780-style character LCD per
// custom-instruction call. The byte and RS are latched on start, followed by
// one setup cycle, a timed enable pulse and a timed low/hold phase. The unit
// then reports completion with a one-cycle done strobe and a result word.
// Every state change, counter step and output update is qualified by clk_en.
module lcd_byte_writer #(
   parameter int EN_HIGH_CYC    = 50000,
   parameter int HOLD_CYC       = 50000,
   parameter int CLEAR_WAIT_CYC = 82000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result,
   output logic        done,
   output logic        lcd_enable,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic [7:0]  lcd_data
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      EN_HIGH = 3'd2,
      EN_LOW  = 3'd3,
      DONE    = 3'd4
   } state_t;

   // Terminal counts. Each phase counts from 0 up to its last value.
   localparam logic [16:0] EN_LAST    = 17'(EN_HIGH_CYC - 1);
   localparam logic [16:0] HOLD_LAST  = 17'(HOLD_CYC - 1);
   localparam logic [16:0] CLEAR_LAST = 17'(CLEAR_WAIT_CYC - 1);

   state_t      state;
   state_t      state_next;
   logic [16:0] counter;
   logic [16:0] counter_next;
   logic [16:0] low_last;
   logic        long_wait;
   logic        load;

   // The upper operand bits carry no meaning for this instruction.
   logic unused_inputs;
   assign unused_inputs = ^{dataa[31:8], datab[31:1]};

   // Clear and home are the two slow HD44780 commands that need the long wait.
   function automatic logic is_long_cmd(input logic [7:0] b, input logic rs);
      return (rs == 1'b0) && ((b == 8'h01) || (b == 8'h02));
   endfunction

   // Next-state and counter logic.
   always_comb begin
      state_next   = state;
      counter_next = counter;
      load         = 1'b0;
      if (long_wait) begin
         low_last = CLEAR_LAST;
      end else begin
         low_last = HOLD_LAST;
      end
      case (state)
         IDLE: begin
            if (start) begin
               load         = 1'b1;
               counter_next = 17'd0;
               state_next   = SETUP;
            end else begin
               state_next   = IDLE;
            end
         end
         SETUP: begin
            counter_next = 17'd0;
            state_next   = EN_HIGH;
         end
         EN_HIGH: begin
            if (counter == EN_LAST) begin
               counter_next = 17'd0;
               state_next   = EN_LOW;
            end else begin
               counter_next = counter + 17'd1;
            end
         end
         EN_LOW: begin
            if (counter == low_last) begin
               counter_next = 17'd0;
               state_next   = DONE;
            end else begin
               counter_next = counter + 17'd1;
            end
         end
         DONE: begin
            counter_next = 17'd0;
            state_next   = IDLE;
         end
         default: begin
            counter_next = 17'd0;
            state_next   = IDLE;
         end
      endcase
   end

   // State, counter and registered bus/result outputs; all hold while clk_en=0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         counter    <= 17'd0;
         long_wait  <= 1'b0;
         lcd_enable <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_rw     <= 1'b0;
         lcd_data   <= 8'h00;
         done       <= 1'b0;
         result     <= 32'd0;
      end else if (clk_en) begin
         state      <= state_next;
         counter    <= counter_next;
         lcd_enable <= (state_next == EN_HIGH);
         done       <= (state_next == DONE);
         if (state_next == DONE) begin
            result <= {22'd0, long_wait, lcd_rs, lcd_data};
         end else begin
            result <= 32'd0;
         end
         if (load) begin
            lcd_data  <= dataa[7:0];
            lcd_rs    <= datab[0];
            lcd_rw    <= 1'b0;
            long_wait <= is_long_cmd(dataa[7:0], datab[0]);
         end
      end
   end

endmodule
